// File: rtl/sm_pkg.sv
// Shared definitions for the sign-magnitude datapath: default width,
// FSM state encodings and helpers that split an SM word into its fields.
package sm_pkg;

  localparam int SM_N = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Sign bit of an SM word at the default width.
  function automatic logic sm_sign(input logic [SM_N:0] w);
    return w[SM_N];
  endfunction

  // Magnitude field of an SM word at the default width.
  function automatic logic [SM_N-1:0] sm_mag(input logic [SM_N:0] w);
    return w[SM_N-1:0];
  endfunction

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator: gt is set when a is strictly greater than b.
module comparator #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         gt
);

  assign gt = (a > b);

endmodule

// File: rtl/sm_bit_slice.sv
// One bit of the serial adder: full adder whose B input is inverted when
// sub is set, so L + ~S + 1 (carry-in seeded by the parent) yields L - S.
module sm_bit_slice (
  input  logic l,
  input  logic s,
  input  logic sub,
  input  logic cin,
  output logic r,
  output logic cout
);

  logic s_eff;

  assign s_eff = s ^ sub;
  assign r     = l ^ s_eff ^ cin;
  assign cout  = (l & s_eff) | (l & cin) | (s_eff & cin);

endmodule

// File: rtl/sm_serial_addsub.sv
// Bit-serial sign-magnitude add/subtract. The operand with the larger
// magnitude is placed in L so a subtraction never needs a final negate;
// the sign is then known up front and only the -0 case is fixed at the end.
// Requires N >= 2.
module sm_serial_addsub
  import sm_pkg::*;
#(
  parameter int N = SM_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N:0]   a,
  input  logic [N:0]   b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   result,
  output logic         ovflw
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, next_state;
  logic [N-1:0]  l_q, s_q, acc_q;
  logic          carry_q, sub_q, sign_q;
  logic [CW-1:0] bitcnt_q;

  logic          accept, last_bit;
  logic          swap, sb, sub_in;
  logic          r_bit, c_out;
  logic [N-1:0]  mag_next;

  assign sb     = b[N] ^ op;
  assign sub_in = a[N] ^ sb;
  assign accept = in_valid & in_ready;
  assign last_bit = (state == S_RUN) && (bitcnt_q == LAST);
  assign mag_next = {r_bit, acc_q[N-1:1]};

  comparator #(.n(N)) u_cmp (
    .a  (b[N-1:0]),
    .b  (a[N-1:0]),
    .gt (swap)
  );

  sm_bit_slice u_slice (
    .l    (l_q[0]),
    .s    (s_q[0]),
    .sub  (sub_q),
    .cin  (carry_q),
    .r    (r_bit),
    .cout (c_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: flops use non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: accept in IDLE, N bit cycles in RUN, wait for consumer in DONE.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned
    // (which would infer a latch).
    next_state = state;
    case (state)
      S_IDLE:  if (accept)    next_state = S_RUN;
      S_RUN:   if (last_bit)  next_state = S_DONE;
      S_DONE:  if (out_ready) next_state = S_IDLE;
      default:                next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Datapath: operand load/ordering, serial shift, and result capture on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q      <= '0;
      s_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      sign_q   <= 1'b0;
      bitcnt_q <= '0;
      result   <= '0;
      ovflw    <= 1'b0;
    end else if (accept) begin
      l_q      <= swap ? b[N-1:0] : a[N-1:0];
      s_q      <= swap ? a[N-1:0] : b[N-1:0];
      sub_q    <= sub_in;
      sign_q   <= swap ? sb : a[N];
      carry_q  <= sub_in;
      bitcnt_q <= '0;
    end else if (state == S_RUN) begin
      l_q      <= l_q >> 1;
      s_q      <= s_q >> 1;
      carry_q  <= c_out;
      acc_q    <= mag_next;
      bitcnt_q <= last_bit ? '0 : bitcnt_q + 1'b1;
      if (last_bit) begin
        // A zero magnitude always reports +0.
        result <= {sign_q & (|mag_next), mag_next};
        ovflw  <= ~sub_q & c_out;
      end
    end
  end

endmodule

// File: tb/tb_sm_serial_addsub.sv
// Self-checking bench for sm_serial_addsub (N=4): directed cases, back-pressure,
// mid-operation reset and an exhaustive operand/op sweep against an SM model.
module tb_sm_serial_addsub;
  import sm_pkg::*;

  localparam int N = SM_N;

  typedef struct {
    logic [N:0] res;
    logic       ovf;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, op, ovflw;
  logic [N:0] a, b, result;

  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  sm_serial_addsub #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovflw     (ovflw)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural SM model: signed integer arithmetic, then back to SM with wrap.
  function automatic exp_t model(input logic [N:0] x, input logic [N:0] y, input logic o);
    exp_t e;
    int av, bv, t, m;
    av = sm_sign(x) ? -int'(sm_mag(x)) : int'(sm_mag(x));
    bv = sm_sign(y) ? -int'(sm_mag(y)) : int'(sm_mag(y));
    t  = o ? av - bv : av + bv;
    m  = (t < 0) ? -t : t;
    e.ovf = (m > (2**N - 1));
    e.res[N-1:0] = N'(m % (2**N));
    e.res[N] = (t < 0) && ((m % (2**N)) != 0);
    e.acc = 0;
    return e;
  endfunction

  // Issue one operation, check latency and result, optionally stall the consumer.
  task automatic run_op(input logic [N:0] ta, input logic [N:0] tb_v, input logic to, input int stall);
    exp_t e;
    int   w;
    @(negedge clk);
    a = ta; b = tb_v; op = to; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(negedge clk);
    e = model(ta, tb_v, to);
    e.acc = cycle;
    sb_q.push_back(e);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", out_valid, 1);
      sb_q.delete();
      return;
    end
    e = sb_q.pop_front();
    check("latency", cycle - e.acc, N);
    check("result", result, e.res);
    check("ovflw", ovflw, e.ovf);
    if (stall > 0) begin
      in_valid = 1'b1;
      a = 5'b01111; b = 5'b10001; op = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("bp_result_stable", result, e.res);
        check("bp_ovflw_stable", ovflw, e.ovf);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_ovflw", ovflw, 0);
    rst_n = 1'b1;

    // Directed cases.
    run_op(5'b00101, 5'b00011, 1'b1, 0);  // +5 - +3 = +2
    run_op(5'b00011, 5'b00101, 1'b1, 0);  // +3 - +5 = -2
    run_op(5'b10110, 5'b00100, 1'b0, 0);  // -6 + +4 = -2
    run_op(5'b11001, 5'b01001, 1'b1, 0);  // -9 - +9 -> -2, ovflw
    run_op(5'b00111, 5'b00111, 1'b1, 0);  // +7 - +7 = +0
    run_op(5'b10000, 5'b00000, 1'b1, 0);  // -0 - +0 = +0

    // Back-pressure, then a fresh operation from IDLE.
    run_op(5'b00011, 5'b00010, 1'b0, 3);
    run_op(5'b00110, 5'b10010, 1'b0, 0);  // +6 + -2 = +4

    // Reset during the second RUN cycle.
    @(negedge clk);
    a = 5'b00011; b = 5'b00010; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(5'b00001, 5'b00001, 1'b0, 0);  // +1 + +1 = +2

    // Exhaustive sweep.
    for (int ia = 0; ia < 32; ia++)
      for (int ib = 0; ib < 32; ib++)
        for (int io = 0; io < 2; io++)
          run_op(5'(ia), 5'(ib), 1'(io), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
